// File: rtl/seq_gen_pkg.sv
// Shared encodings for the serial sequence generator: FSM state codes and preamble pattern.
package seq_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRE   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam logic [2:0] PREAMBLE = 3'b101;
   localparam int         PRE_LEN  = 3;

endpackage

// File: rtl/seq_gen_shift_reg.sv
// Parallel-load shift register feeding the serializer; exposes the head bit, the bit behind it,
// and the bit that would be at the head if data were loaded now.
module seq_shift_reg
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             head,
   output logic             peek,
   output logic             load_bit
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= data;
      end else if (shift) begin
         sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      end
   end

   assign head     = MSB_FIRST ? sr[WIDTH-1]   : sr[0];
   assign peek     = MSB_FIRST ? sr[WIDTH-2]   : sr[1];
   assign load_bit = MSB_FIRST ? data[WIDTH-1] : data[0];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern generator: accepts words over valid/ready and shifts them out one bit per clock.
// Optional 1,0,1 preamble before each word when SEQ_GEN_PREAMBLE_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for a word, seq_out=0, data_ready=1
//  PRE   | emitting the 3-bit preamble (only with SEQ_GEN_PREAMBLE_EN)
//  SHIFT | emitting data bits, bit_cnt counts down to the last bit
//  GAP   | GAP_CYCLES idle bits after a word, data_ready=0
module seq_gen
   import seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             seq_out,
   output logic             busy,
   output logic             word_done
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
`ifdef SEQ_GEN_PREAMBLE_EN
   localparam logic [1:0]       START_ST = PRE;
   localparam logic [1:0]       PRE_LOAD = 2'(PRE_LEN - 1);
`else
   localparam logic [1:0]       START_ST = SHIFT;
`endif

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [3:0]       gap_cnt;
   logic             seq_out_nxt;
   logic             accept;
   logic             last_bit;
   logic             sr_shift;
   logic             sr_head;
   logic             sr_peek;
   logic             sr_load_bit;
`ifdef SEQ_GEN_PREAMBLE_EN
   logic [1:0]       pre_cnt;
`endif

   assign accept   = data_valid & data_ready;
   assign last_bit = (state == SHIFT) && (bit_cnt == '0);
   assign sr_shift = (state == SHIFT) && (bit_cnt != '0);

   seq_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clock    (clock),
      .reset    (reset),
      .load     (accept),
      .shift    (sr_shift),
      .data     (data_in),
      .head     (sr_head),
      .peek     (sr_peek),
      .load_bit (sr_load_bit)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = START_ST;
         end
`ifdef SEQ_GEN_PREAMBLE_EN
         PRE: begin
            if (pre_cnt == 2'd0) state_nxt = SHIFT;
         end
`endif
         SHIFT: begin
            if (last_bit) begin
               if (GAP_CYCLES > 0)  state_nxt = GAP;
               else if (accept)     state_nxt = START_ST;
               else                 state_nxt = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      data_ready = (state == IDLE) | (last_bit & (GAP_CYCLES == 0));
      busy       = (state != IDLE);
      word_done  = last_bit;
   end

   // seq_out is registered, so compute the bit that the next state will present.
   always_comb begin
      seq_out_nxt = 1'b0;
      case (state_nxt)
         SHIFT: begin
            if ((state == SHIFT) && !last_bit) seq_out_nxt = sr_peek;
            else if (accept)                   seq_out_nxt = sr_load_bit;
            else                               seq_out_nxt = sr_head;
         end
`ifdef SEQ_GEN_PREAMBLE_EN
         PRE: begin
            if (accept) seq_out_nxt = PREAMBLE[PRE_LOAD];
            else        seq_out_nxt = PREAMBLE[2'(pre_cnt - 2'd1)];
         end
`endif
         default: seq_out_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seq_out <= 1'b0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         seq_out <= seq_out_nxt;
         if (accept) begin
            bit_cnt <= BIT_LOAD;
         end else if (sr_shift) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
         end
         if (last_bit) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

`ifdef SEQ_GEN_PREAMBLE_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_cnt <= 2'd0;
      end else if (accept) begin
         pre_cnt <= PRE_LOAD;
      end else if ((state == PRE) && (pre_cnt != 2'd0)) begin
         pre_cnt <= pre_cnt - 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one gap-free instance and one GAP_CYCLES=2 instance.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready, seq_out, busy, word_done;

   logic [7:0] g_data_in = 8'h00;
   logic       g_data_valid = 1'b0;
   logic       g_data_ready, g_seq_out, g_busy, g_word_done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   seq_gen #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u_dut (
      .clock      (clk),
      .reset      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .seq_out    (seq_out),
      .busy       (busy),
      .word_done  (word_done)
   );

   seq_gen #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) u_gap (
      .clock      (clk),
      .reset      (rst_n),
      .data_in    (g_data_in),
      .data_valid (g_data_valid),
      .data_ready (g_data_ready),
      .seq_out    (g_seq_out),
      .busy       (g_busy),
      .word_done  (g_word_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] s;
      logic [2:0]  hist;
      int          hits;
`ifdef SEQ_GEN_PREAMBLE_EN
      logic [10:0] p;
`endif

      #12;
      chk("rst_seq_out", 32'(seq_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_word_done", 32'(word_done), 32'd0);
      chk("rst_data_ready", 32'(data_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef SEQ_GEN_PREAMBLE_EN
      // preamble 1,0,1 then eight zeros; detector model counts 101 patterns
      p = 11'b101_0000_0000;
      hist = 3'b000;
      hits = 0;
      data_in = 8'h00; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 11) chk("t6_bit", 32'(seq_out), 32'(p[10-i]));
         else        chk("t6_idle", 32'(seq_out), 32'd0);
         chk("t6_done", 32'(word_done), 32'(i == 10));
         if (i < 3) chk("t6_ready", 32'(data_ready), 32'd0);
         hist = {hist[1:0], seq_out};
         if (hist == 3'b101) hits++;
      end
      chk("t6_hits", 32'(hits), 32'd1);
      chk("t6_busy_end", 32'(busy), 32'd0);
`else
      // 1: single word A5
      w = 8'hA5;
      data_in = w; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("t1_bit", 32'(seq_out), 32'(w[7-i]));
         chk("t1_done", 32'(word_done), 32'(i == 7));
         chk("t1_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("t1_idle_out", 32'(seq_out), 32'd0);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_idle_ready", 32'(data_ready), 32'd1);

      // 2: FF then 00 back to back
      data_in = 8'hFF; data_valid = 1'b1;
      @(negedge clk);
      data_in = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 8) data_valid = 1'b0;
         chk("t2_bit", 32'(seq_out), 32'(i < 8));
         chk("t2_busy", 32'(busy), 32'd1);
         chk("t2_done", 32'(word_done), 32'((i == 7) || (i == 15)));
         chk("t2_ready", 32'(data_ready), 32'((i == 7) || (i == 15)));
      end
      @(negedge clk);
      chk("t2_end_busy", 32'(busy), 32'd0);

      // 3: gap instance, FF followed by two idle cycles
      g_data_in = 8'hFF; g_data_valid = 1'b1;
      @(negedge clk);
      g_data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("t3_bit", 32'(g_seq_out), 32'd1);
         chk("t3_done", 32'(g_word_done), 32'(i == 7));
         chk("t3_ready", 32'(g_data_ready), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t3_gap_out", 32'(g_seq_out), 32'd0);
         chk("t3_gap_ready", 32'(g_data_ready), 32'd0);
         chk("t3_gap_busy", 32'(g_busy), 32'd1);
         chk("t3_gap_done", 32'(g_word_done), 32'd0);
      end
      @(negedge clk);
      chk("t3_idle_ready", 32'(g_data_ready), 32'd1);
      chk("t3_idle_busy", 32'(g_busy), 32'd0);

      // 4: reset during bit 4 of F0
      data_in = 8'hF0; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("t4_pre_bit", 32'(seq_out), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_rst_out", 32'(seq_out), 32'd0);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_done", 32'(word_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_after_out", 32'(seq_out), 32'd0);
         chk("t4_after_busy", 32'(busy), 32'd0);
         chk("t4_after_ready", 32'(data_ready), 32'd1);
      end

      // 5: 3C offered mid-word of 96, must wait for data_ready
      s = {8'h96, 8'h3C};
      data_in = 8'h96; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         chk("t5_bit", 32'(seq_out), 32'(s[15-i]));
         chk("t5_ready", 32'(data_ready), 32'((i == 7) || (i == 15)));
         chk("t5_done", 32'(word_done), 32'((i == 7) || (i == 15)));
         if (i == 2) begin
            data_in = 8'h3C; data_valid = 1'b1;
         end
         if (i == 8) data_valid = 1'b0;
      end
      @(negedge clk);
      chk("t5_end_busy", 32'(busy), 32'd0);
      chk("t5_end_out", 32'(seq_out), 32'd0);

      // 6: 05 into a 101 detector model, exactly one match
      hist = 3'b000;
      hits = 0;
      data_in = 8'h05; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         chk("t6_done", 32'(word_done), 32'(i == 7));
         hist = {hist[1:0], seq_out};
         if (hist == 3'b101) hits++;
      end
      chk("t6_hits", 32'(hits), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
